// File: rtl/sale_terminal_pkg.sv
// -----------------------------------------------------------------------------
// sale_terminal_pkg
// Shared definitions for the sale-terminal front-panel logic:
//   - hold_state_e     : per-button hold FSM states (idle / held / auto-repeat)
//   - hold_cnt_width() : width of the hold counter, wide enough for the larger
//                        of the long-press and repeat periods
//   - DEFAULT_*        : timing defaults for a 50 MHz system clock
// No ports (package).
// -----------------------------------------------------------------------------
package sale_terminal_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_HOLD   = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_e;

  // Defaults for a 50 MHz clock: ~1.3 ms debounce window, 0.5 s long press,
  // 100 ms auto-repeat period.
  localparam int DEFAULT_NUM_BUTTONS       = 4;
  localparam int DEFAULT_COUNTER_REG_SIZE  = 16;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 25_000_000;
  localparam int DEFAULT_REPEAT_CYCLES     = 5_000_000;

  // One spare bit above the larger period so the counter can hold the
  // saturated long-press value without wrapping.
  function automatic int hold_cnt_width(input int long_cycles, input int repeat_cycles);
    return $clog2((long_cycles > repeat_cycles) ? long_cycles : repeat_cycles) + 1;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// -----------------------------------------------------------------------------
// button_debounce_channel
// One button: two-flop synchroniser, debounce counter, press/release pulse
// generation and the hold FSM producing long-press and auto-repeat pulses.
// Ports:
//   CLK              in   system clock
//   RST              in   synchronous, active-high reset
//   noisy_in         in   raw asynchronous button input
//   clean            out  debounced level, 1 = pressed
//   press_pulse      out  1-cycle pulse, first cycle clean is 1
//   release_pulse    out  1-cycle pulse, first cycle clean is 0
//   long_press_pulse out  1-cycle pulse LONG_PRESS_CYCLES after clean rose
//   repeat_pulse     out  1-cycle pulse every REPEAT_CYCLES after long press
// -----------------------------------------------------------------------------
module button_debounce_channel
  import sale_terminal_pkg::*;
#(
  parameter int COUNTER_REG_SIZE  = DEFAULT_COUNTER_REG_SIZE,
  parameter int INPUT_ACTIVE_LOW  = 1,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES,
  parameter int REPEAT_EN         = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic noisy_in,
  output logic clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse
);

  localparam int HOLD_W = hold_cnt_width(LONG_PRESS_CYCLES, REPEAT_CYCLES);
  localparam logic [HOLD_W-1:0] LONG_LIM   = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] REPEAT_LIM = HOLD_W'(REPEAT_CYCLES);

  // State register kept as a plain vector for compatibility with existing
  // netlists; the encodings come from the shared enum.
  localparam logic [1:0] ST_IDLE   = HOLD_IDLE;
  localparam logic [1:0] ST_HOLD   = HOLD_HOLD;
  localparam logic [1:0] ST_REPEAT = HOLD_REPEAT;

  logic                        sync0;
  logic                        sync1;
  logic [COUNTER_REG_SIZE-1:0] db_cnt;
  logic                        toggle;
  logic                        rise;
  logic                        fall;
  logic [1:0]                  state;
  logic [HOLD_W-1:0]           hold_cnt;
  logic [HOLD_W-1:0]           hold_inc;

  // The clean level flips on the edge where a full window of mismatches
  // completes.
  assign toggle   = (sync1 != clean) && (db_cnt == '1);
  assign rise     = toggle && !clean;
  assign fall     = toggle && clean;
  assign hold_inc = hold_cnt + HOLD_W'(1);

  // NOTE: every clocked assignment uses <= so all flops sample the values from
  // before the edge; a blocking = here would collapse the synchroniser chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= (INPUT_ACTIVE_LOW != 0) ? ~noisy_in : noisy_in;
      sync1 <= sync0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      db_cnt        <= '0;
      clean         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      if (sync1 == clean) begin
        db_cnt <= '0;
      end else if (db_cnt == '1) begin
        db_cnt <= '0;
        clean  <= ~clean;
      end else begin
        db_cnt <= db_cnt + COUNTER_REG_SIZE'(1);
      end
    end
  end

  // Hold FSM. It sees the registered clean level, so it leaves IDLE one edge
  // after the rise; the count then equals the number of cycles clean has been
  // high, which places the long-press pulse exactly LONG_PRESS_CYCLES after
  // the press pulse. The fall edge is caught from the debouncer directly so
  // no long/repeat pulse can land in the release cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= ST_IDLE;
      hold_cnt         <= '0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
    end else begin
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      if (!clean || fall) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_HOLD: begin
            // hold_cnt == LONG_LIM only when saturated after a long press
            // with auto-repeat disabled.
            if (hold_cnt != LONG_LIM) begin
              state    <= ST_HOLD;
              hold_cnt <= hold_inc;
              if (hold_inc == LONG_LIM) begin
                long_press_pulse <= 1'b1;
                if (REPEAT_EN != 0) begin
                  state    <= ST_REPEAT;
                  hold_cnt <= '0;
                end
              end
            end
          end
          ST_REPEAT: begin
            if (hold_inc == REPEAT_LIM) begin
              repeat_pulse <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= hold_inc;
            end
          end
          default: begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer_array.sv
// -----------------------------------------------------------------------------
// button_debouncer_array
// NUM_BUTTONS independent debounce channels feeding the menu/entry controller
// with clean levels and single-cycle button events.
// Ports:
//   CLK             in   system clock
//   RST             in   synchronous, active-high reset
//   NoisyButtonIn   in   raw button inputs (polarity per INPUT_ACTIVE_LOW)
//   CleanButtonOut  out  debounced levels, 1 = pressed
//   PressPulse      out  per-channel press events
//   ReleasePulse    out  per-channel release events
//   LongPressPulse  out  per-channel long-press events
//   RepeatPulse     out  per-channel auto-repeat events
//   AnyPressed      out  OR of CleanButtonOut
// -----------------------------------------------------------------------------
module button_debouncer_array
  import sale_terminal_pkg::*;
#(
  parameter int NUM_BUTTONS       = DEFAULT_NUM_BUTTONS,
  parameter int COUNTER_REG_SIZE  = DEFAULT_COUNTER_REG_SIZE,
  parameter int INPUT_ACTIVE_LOW  = 1,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES,
  parameter int REPEAT_EN         = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_BUTTONS-1:0] NoisyButtonIn,
  output logic [NUM_BUTTONS-1:0] CleanButtonOut,
  output logic [NUM_BUTTONS-1:0] PressPulse,
  output logic [NUM_BUTTONS-1:0] ReleasePulse,
  output logic [NUM_BUTTONS-1:0] LongPressPulse,
  output logic [NUM_BUTTONS-1:0] RepeatPulse,
  output logic                   AnyPressed
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debounce_channel #(
      .COUNTER_REG_SIZE (COUNTER_REG_SIZE),
      .INPUT_ACTIVE_LOW (INPUT_ACTIVE_LOW),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES),
      .REPEAT_EN        (REPEAT_EN)
    ) u_ch (
      .CLK             (CLK),
      .RST             (RST),
      .noisy_in        (NoisyButtonIn[i]),
      .clean           (CleanButtonOut[i]),
      .press_pulse     (PressPulse[i]),
      .release_pulse   (ReleasePulse[i]),
      .long_press_pulse(LongPressPulse[i]),
      .repeat_pulse    (RepeatPulse[i])
    );
  end

  // Clean levels are already registered, so the OR adds no cycle of delay.
  assign AnyPressed = |CleanButtonOut;

endmodule

// File: tb/tb_button_debouncer_array.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer_array
// Two instances (auto-repeat on / off) share one set of stimulus. A reference
// model derives expected outputs from the button history by timestamps:
// a level is accepted once the synchronised input has disagreed with the
// clean level for a full window, and long/repeat events are pure arithmetic on
// the time since the debounced press.
// -----------------------------------------------------------------------------
module tb_button_debouncer_array;

  localparam int NB     = 4;
  localparam int CRS    = 3;
  localparam int LONG   = 20;
  localparam int REP    = 8;
  localparam int DB_WIN = 1 << CRS;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NB-1:0] btn = '1;

  logic [NB-1:0] clean0, press0, rel0, long0, rep0;
  logic          any0;
  logic [NB-1:0] clean1, press1, rel1, long1, rep1;
  logic          any1;

  always #5 CLK = ~CLK;

  button_debouncer_array #(
    .NUM_BUTTONS(NB), .COUNTER_REG_SIZE(CRS), .INPUT_ACTIVE_LOW(1),
    .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
  ) u_dut0 (
    .CLK(CLK), .RST(RST), .NoisyButtonIn(btn), .CleanButtonOut(clean0),
    .PressPulse(press0), .ReleasePulse(rel0), .LongPressPulse(long0),
    .RepeatPulse(rep0), .AnyPressed(any0)
  );

  button_debouncer_array #(
    .NUM_BUTTONS(NB), .COUNTER_REG_SIZE(CRS), .INPUT_ACTIVE_LOW(1),
    .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(0)
  ) u_dut1 (
    .CLK(CLK), .RST(RST), .NoisyButtonIn(btn), .CleanButtonOut(clean1),
    .PressPulse(press1), .ReleasePulse(rel1), .LongPressPulse(long1),
    .RepeatPulse(rep1), .AnyPressed(any1)
  );

  int check_cnt = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int            edge_no = 0;
  bit            lvl_hist [NB][16];   // pressed level sampled at each edge
  bit            m_clean  [NB];
  int            rise_t   [NB];       // edge at which clean last rose, -1 if low
  logic [NB-1:0] exp_clean, exp_press, exp_rel, exp_long, exp_rep;

  task automatic model_step();
    int  idx;
    int  d;
    bit  v;
    bit  stable;
    edge_no++;
    exp_press = '0;
    exp_rel   = '0;
    exp_long  = '0;
    exp_rep   = '0;
    for (int c = 0; c < NB; c++) begin
      if (RST) begin
        lvl_hist[c][edge_no % 16] = 1'b0;
        m_clean[c] = 1'b0;
        rise_t[c]  = -1;
      end else begin
        lvl_hist[c][edge_no % 16] = ~btn[c];
        // Synchroniser: the sample taken at edge e reaches the debouncer's
        // comparison at edge e+2, so the window is samples e-2 .. e-1-DB_WIN.
        stable = 1'b1;
        for (int k = 2; k <= DB_WIN + 1; k++) begin
          idx = edge_no - k;
          v   = (idx <= 0) ? 1'b0 : lvl_hist[c][idx % 16];
          if (v == m_clean[c]) stable = 1'b0;
        end
        if (stable) begin
          m_clean[c] = ~m_clean[c];
          if (m_clean[c]) begin
            exp_press[c] = 1'b1;
            rise_t[c]    = edge_no;
          end else begin
            exp_rel[c] = 1'b1;
            rise_t[c]  = -1;
          end
        end else if (m_clean[c] && rise_t[c] >= 0) begin
          d = edge_no - rise_t[c];
          if (d == LONG) exp_long[c] = 1'b1;
          if (d > LONG && ((d - LONG) % REP) == 0) exp_rep[c] = 1'b1;
        end
      end
      exp_clean[c] = m_clean[c];
    end
  endtask

  // Observed-event counters for the directed scenarios.
  int press_cnt [NB];
  int long_cnt1 [NB];
  int rep_cnt1  [NB];

  initial begin
    for (int c = 0; c < NB; c++) begin
      m_clean[c]   = 1'b0;
      rise_t[c]    = -1;
      press_cnt[c] = 0;
      long_cnt1[c] = 0;
      rep_cnt1[c]  = 0;
      for (int k = 0; k < 16; k++) lvl_hist[c][k] = 1'b0;
    end
    forever begin
      @(posedge CLK);
      model_step();
      #1;
      check("clean_r1", clean0, exp_clean);
      check("press_r1", press0, exp_press);
      check("rel_r1",   rel0,   exp_rel);
      check("long_r1",  long0,  exp_long);
      check("rep_r1",   rep0,   exp_rep);
      check("any_r1",   any0,   |exp_clean);
      check("clean_r0", clean1, exp_clean);
      check("press_r0", press1, exp_press);
      check("rel_r0",   rel1,   exp_rel);
      check("long_r0",  long1,  exp_long);
      check("rep_r0",   rep1,   '0);
      check("any_r0",   any1,   |exp_clean);
      for (int c = 0; c < NB; c++) begin
        if (press0[c] === 1'b1) press_cnt[c]++;
        if (long1[c]  === 1'b1) long_cnt1[c]++;
        if (rep1[c]   === 1'b1) rep_cnt1[c]++;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic pulse_bit(input int sel, input int ch);
    case (sel)
      0:       return press0[ch];
      1:       return rel0[ch];
      2:       return long0[ch];
      default: return rep0[ch];
    endcase
  endfunction

  // Counts rising edges until the selected repeat-enabled pulse is seen;
  // returns -1 if it does not appear within the limit.
  task automatic wait_pulse(input int sel, input int ch, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge CLK);
      #1;
      if (pulse_bit(sel, ch) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p_before;
    int l_before;
    int r_before;
    int dwell [NB];
    int rst_left;

    // 1. Reset, then debounce latency on ch0.
    RST = 1'b1;
    btn = '1;
    idle(3);
    RST = 1'b0;
    idle(12);
    btn[0] = 1'b0;
    wait_pulse(0, 0, 40, n);
    check("lat_press_ch0", n, 10);
    check("any_after_press", any0, 1);
    @(negedge CLK);
    btn[0] = 1'b1;
    wait_pulse(1, 0, 40, n);
    check("lat_release_ch0", n, 10);
    idle(5);

    // 2. Glitch rejection on ch1: 7 low samples rejected, 8 accepted.
    p_before = press_cnt[1];
    btn[1] = 1'b0;
    idle(7);
    btn[1] = 1'b1;
    idle(20);
    check("glitch7_rejected", press_cnt[1] - p_before, 0);
    btn[1] = 1'b0;
    idle(8);
    btn[1] = 1'b1;
    idle(20);
    check("glitch8_accepted", press_cnt[1] - p_before, 1);

    // 3. Long press and repeat on ch2; release timed so the debounced fall
    //    lands on a would-be repeat cycle.
    btn[2] = 1'b0;
    wait_pulse(0, 2, 40, n);
    check("lat_press_ch2", n, 10);
    wait_pulse(2, 2, 40, n);
    check("long_delay", n, LONG);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(3, 2, 40, n);
      check("repeat_period", n, REP);
    end
    idle(7);
    btn[2] = 1'b1;
    wait_pulse(1, 2, 40, n);
    check("lat_release_ch2", n, 10);
    idle(5);

    // 4. Release before the long press on ch3 (15 debounced cycles).
    btn[3] = 1'b0;
    wait_pulse(0, 3, 40, n);
    check("lat_press_ch3", n, 10);
    idle(6);
    btn[3] = 1'b1;
    wait_pulse(1, 3, 40, n);
    check("lat_release_ch3", n, 10);
    idle(5);

    // 5. ch0 and ch3 together.
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    wait_pulse(0, 0, 40, n);
    check("simul_press0", n, 10);
    check("simul_press3", press0[3], 1);
    idle(30);
    btn[0] = 1'b1;
    idle(5);
    btn[3] = 1'b1;
    idle(15);

    // 6. Reset in the REPEAT state with ch2 still held.
    btn[2] = 1'b0;
    wait_pulse(0, 2, 40, n);
    check("pre_rst_press", n, 10);
    wait_pulse(2, 2, 40, n);
    check("pre_rst_long", n, LONG);
    wait_pulse(3, 2, 40, n);
    check("pre_rst_repeat", n, REP);
    @(negedge CLK);
    RST = 1'b1;
    idle(3);
    RST = 1'b0;
    wait_pulse(0, 2, 40, n);
    check("post_rst_press", n, 10);
    l_before = long_cnt1[2];
    r_before = rep_cnt1[2];
    wait_pulse(2, 2, 40, n);
    check("post_rst_long", n, LONG);
    idle(40);
    check("norep_long_once", long_cnt1[2] - l_before, 1);
    check("norep_no_repeat", rep_cnt1[2] - r_before, 0);
    btn[2] = 1'b1;
    idle(15);

    // Random phase: mixed short bounces and long holds, occasional reset.
    for (int c = 0; c < NB; c++) dwell[c] = $urandom_range(1, 12);
    rst_left = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge CLK);
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) RST = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        RST      = 1'b1;
        rst_left = $urandom_range(1, 3);
      end
      for (int c = 0; c < NB; c++) begin
        dwell[c]--;
        if (dwell[c] <= 0) begin
          btn[c]   = ~btn[c];
          dwell[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70)
                                                 : $urandom_range(1, 12);
        end
      end
    end
    RST = 1'b0;
    btn = '1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
